spi_serf_regs: RTL and testbench

//  SPI serf (responder) for the 16-bit, mode-0 frames issued by the Knight's SPI monarch. It holds an
//  8-bit register file, modelled on the inertial sensor, that the monarch reads and writes.
//  It is oversampled on the system clock and is the far end of the SS_n/SCLK/MOSI/MISO link.
//  A host port lets physics/model logic load sensor values and observe configuration writes.

---
 rtl/spi_serf_regs_if.sv | 22 ++
 rtl/spi_serf_regs.sv | 88 ++++++++
 tb/tb_spi_serf_regs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_serf_regs_if.sv
// spi_serf_regs_if: SPI link (SS_n/SCLK/MOSI/MISO), host register write port and committed-frame report
interface spi_serf_regs_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic hst_we;
  logic [6:0] hst_addr;
  logic [7:0] hst_wdata;
  logic done;
  logic cmd_rd;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  modport slave(
    input SS_n, SCLK, MOSI, hst_we, hst_addr, hst_wdata,
    output MISO, done, cmd_rd, cmd_addr, cmd_wdata
  );
  modport master(
    output SS_n, SCLK, MOSI, hst_we, hst_addr, hst_wdata,
    input MISO, done, cmd_rd, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/spi_serf_regs.sv
// spi_serf_regs: oversampled mode-0 16-bit SPI responder over an 8-bit register file; ports clk, rst_n (sync, active low), bus (slave: SPI pins, host write, done/cmd_* report)
module spi_serf_regs #(
  parameter int NUM_REGS = 16,
  parameter logic [6:0] WHOAMI_ADDR = 7'h0F,
  parameter logic [7:0] WHOAMI_VAL = 8'h6A
) (
  input logic clk,
  input logic rst_n,
  spi_serf_regs_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [7:0] NR = 8'(NUM_REGS);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic ss_1, ss_s, ss_d;
  logic sclk_1, sclk_s, sclk_d;
  logic mosi_1, mosi_s;
  logic [15:0] rx_shft, rx_nxt;
  logic [7:0] tx_shft, rd_data;
  logic [4:0] bit_cnt;
  logic [7:0] regs [NUM_REGS];
  logic ss_fall, sclk_rise, sclk_fall, commit;
  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NR;
  endfunction
  function automatic logic wr_ok(input logic [6:0] a);
    return in_range(a) && a != WHOAMI_ADDR;
  endfunction
  assign ss_fall = ss_d & ~ss_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_nxt = {rx_shft[14:0], mosi_s};
  assign commit = state_q == SHIFT && ss_s && bit_cnt == 5'd16;
  // rx_nxt[6:0] is the address on the rise that completes the header byte
  always_comb begin
    rd_data = 8'h00;
    if (rx_nxt[6:0] == WHOAMI_ADDR) rd_data = WHOAMI_VAL;
    else if (in_range(rx_nxt[6:0])) rd_data = regs[rx_nxt[AW-1:0]];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = ss_fall ? SHIFT : IDLE;
      SHIFT: state_d = ss_s ? (bit_cnt == 5'd16 ? COMMIT : IDLE) : SHIFT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk)
    if (!rst_n) begin
      {ss_1, ss_s, ss_d} <= 3'b111;
      {sclk_1, sclk_s, sclk_d} <= 3'b000;
      {mosi_1, mosi_s} <= 2'b00;
      rx_shft <= 16'h0000;
      tx_shft <= 8'h00;
      bit_cnt <= 5'd0;
      bus.cmd_rd <= 1'b0;
      bus.cmd_addr <= 7'h00;
      bus.cmd_wdata <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      {ss_1, ss_s, ss_d} <= {bus.SS_n, ss_1, ss_s};
      {sclk_1, sclk_s, sclk_d} <= {bus.SCLK, sclk_1, sclk_s};
      {mosi_1, mosi_s} <= {bus.MOSI, mosi_1};
      if (state_q == IDLE && ss_fall) begin
        bit_cnt <= 5'd0;
        tx_shft <= 8'h00;
      end
      if (state_q == SHIFT && !ss_s) begin
        if (sclk_rise) begin
          rx_shft <= rx_nxt;
          bit_cnt <= bit_cnt == 5'd16 ? bit_cnt : bit_cnt + 5'd1;
          if (bit_cnt == 5'd7 && rx_nxt[7]) tx_shft <= rd_data;
        end else if (sclk_fall && bit_cnt >= 5'd9 && bit_cnt <= 5'd15) tx_shft <= {tx_shft[6:0], 1'b0};
      end
      if (bus.hst_we && wr_ok(bus.hst_addr)) regs[bus.hst_addr[AW-1:0]] <= bus.hst_wdata;
      if (commit) begin
        bus.cmd_rd <= rx_shft[15];
        bus.cmd_addr <= rx_shft[14:8];
        bus.cmd_wdata <= rx_shft[7:0];
        if (!rx_shft[15] && wr_ok(rx_shft[14:8])) regs[rx_shft[8+AW-1:8]] <= rx_shft[7:0];
      end
    end
  assign bus.done = state_q == COMMIT;
  assign bus.MISO = ~ss_s & tx_shft[7];
endmodule

// File: tb/tb_spi_serf_regs.sv
// tb_spi_serf_regs: random and directed SPI frames against a register-file model of the responder
module tb_spi_serf_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_serf_regs_if bus();
  spi_serf_regs dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_regs [16];
  logic m_rd;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic [15:0] r;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] m_read(input logic [6:0] a);
    return a == 7'h0F ? 8'h6A : a < 7'd16 ? m_regs[a[3:0]] : 8'h00;
  endfunction
  function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
    if (a < 7'd16 && a != 7'h0F) m_regs[a[3:0]] = d;
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_rd = 1'b0;
    m_addr = 7'h00;
    m_wdata = 8'h00;
  endfunction
  task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
    bus.hst_addr = a;
    bus.hst_wdata = d;
    bus.hst_we = 1'b1;
    clks(1);
    bus.hst_we = 1'b0;
    m_write(a, d);
  endtask
  // Sends the low nbits of bits MSB first; returns the MISO bits sampled at each SCLK rise.
  task automatic frame(input logic [31:0] bits, input int nbits, input bit same_hw, input bit mid_hw,
                       input logic [7:0] hw_d, output logic [15:0] got16);
    logic [31:0] got = 0;
    logic [31:0] exp = 0;
    logic [7:0] hdr = 0;
    logic [7:0] rv = 0;
    logic [15:0] last = bits[15:0];
    logic e;
    int dn = 0;
    bus.SS_n = 1'b0;
    clks(4);
    for (int k = 1; k <= nbits; k++) begin
      bus.MOSI = bits[nbits-k];
      clks(4);
      e = (k >= 9 && hdr[7]) ? rv[k <= 16 ? 16 - k : 0] : 1'b0;
      got = {got[30:0], bus.MISO};
      exp = {exp[30:0], e};
      bus.SCLK = 1'b1;
      if (k <= 8) hdr = {hdr[6:0], bits[nbits-k]};
      if (k == 8) rv = m_read(hdr[6:0]);
      clks(4);
      bus.SCLK = 1'b0;
      if (mid_hw && k == 10) host_wr(hdr[6:0], hw_d);
    end
    clks(4);
    chk("miso", got, exp);
    got16 = got[15:0];
    @(posedge clk);
    #1;
    bus.SS_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3 && same_hw) begin
        bus.hst_addr = last[14:8];
        bus.hst_wdata = hw_d;
        bus.hst_we = 1'b1;
      end
      clks(1);
      bus.hst_we = 1'b0;
      if (bus.done) dn++;
    end
    if (same_hw) m_write(last[14:8], hw_d);
    if (nbits >= 16) begin
      m_rd = last[15];
      m_addr = last[14:8];
      m_wdata = last[7:0];
      if (!m_rd) m_write(m_addr, m_wdata);
    end
    chk("done_cnt", dn, nbits >= 16 ? 1 : 0);
    chk("cmd_rd", bus.cmd_rd, m_rd);
    chk("cmd_addr", bus.cmd_addr, m_addr);
    chk("cmd_wdata", bus.cmd_wdata, m_wdata);
    clks(2);
  endtask
  initial begin
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    bus.hst_we = 1'b0;
    bus.hst_addr = 7'h00;
    bus.hst_wdata = 8'h00;
    m_reset();
    clks(3);
    rst_n = 1'b1;
    clks(2);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_miso", bus.MISO, 1'b0);
    chk("rst_cmd", {bus.cmd_rd, bus.cmd_addr, bus.cmd_wdata}, 16'h0000);
    frame(32'h0D02, 16, 0, 0, 0, r);
    chk("wr_cmd", {bus.cmd_rd, bus.cmd_addr, bus.cmd_wdata}, 16'h0D02);
    frame(32'h8D00, 16, 0, 0, 0, r);
    chk("rd_0d", r, 16'h0002);
    frame(32'h8F00, 16, 0, 0, 0, r);
    chk("whoami", r, 16'h006A);
    chk("whoami_cmd", {bus.cmd_rd, bus.cmd_addr}, 8'h8F);
    host_wr(7'h02, 8'hA5);
    frame(32'h8200, 16, 0, 0, 0, r);
    chk("host_rd", r, 16'h00A5);
    frame(32'h0F55, 16, 0, 0, 0, r);
    frame(32'h8F00, 16, 0, 0, 0, r);
    chk("whoami_ro", r, 16'h006A);
    frame(32'h0377 >> 6, 10, 0, 0, 0, r);
    chk("abort_cmd", {bus.cmd_rd, bus.cmd_addr, bus.cmd_wdata}, 16'h8F00);
    frame(32'h8300, 16, 0, 0, 0, r);
    chk("abort_reg", r, 16'h0000);
    frame(32'h0422, 16, 1, 0, 8'h11, r);
    frame(32'h8400, 16, 0, 0, 0, r);
    chk("spi_wins", r, 16'h0022);
    frame(32'hA000, 16, 0, 0, 0, r);
    chk("bad_addr", r, 16'h0000);
    frame(32'h8200, 16, 0, 1, 8'h5A, r);
    chk("inflight", r, 16'h00A5);
    frame(32'h8200, 16, 0, 0, 0, r);
    chk("late_host", r, 16'h005A);
    frame(32'hF0D33, 20, 0, 0, 0, r);
    frame(32'h8D00, 16, 0, 0, 0, r);
    chk("long_frame", r, 16'h0033);
    bus.SS_n = 1'b0;
    clks(4);
    for (int k = 1; k <= 5; k++) begin
      bus.MOSI = k == 1;
      clks(4);
      bus.SCLK = 1'b1;
      clks(4);
      bus.SCLK = 1'b0;
    end
    rst_n = 1'b0;
    clks(2);
    bus.SS_n = 1'b1;
    clks(3);
    rst_n = 1'b1;
    m_reset();
    clks(2);
    chk("mid_rst_cmd", {bus.cmd_rd, bus.cmd_addr, bus.cmd_wdata}, 16'h0000);
    frame(32'h8F00, 16, 0, 0, 0, r);
    chk("rst_whoami", r, 16'h006A);
    for (int a = 0; a < 16; a++) begin
      frame(32'h8000 | (a << 8), 16, 0, 0, 0, r);
      chk("rst_regs", r, a == 15 ? 16'h006A : 16'h0000);
    end
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 9);
      int nb = sel == 0 ? $urandom_range(1, 15) : sel == 1 ? $urandom_range(17, 24) : 16;
      logic [31:0] bits = $urandom;
      bits[14:8] = 7'($urandom_range(0, 19));
      if ($urandom_range(0, 2) == 0) host_wr(7'($urandom_range(0, 17)), 8'($urandom));
      frame(bits, nb, nb >= 16 && $urandom_range(0, 4) == 0, nb >= 10 && $urandom_range(0, 3) == 0,
            8'($urandom), r);
    end
    for (int a = 0; a < 18; a++) begin
      frame(32'h8000 | (a << 8), 16, 0, 0, 0, r);
      chk("final_regs", r, {8'h00, m_read(7'(a))});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
